// File: rtl/row_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : row_read_arbiter
// Purpose  : Round-robin arbiter sharing one single-port, row-wide image
//            memory among N_REQ read clients. Each client asks for a burst of
//            consecutive rows; the arbiter issues one memory read per cycle
//            and routes returned rows back with per-client valid/last strobes.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            req             - per-client request level
//            req_addr        - per-client start row   [i*ROW_AW +: ROW_AW]
//            req_len         - per-client rows-1      [i*LEN_W  +: LEN_W]
//            gnt / err       - one-cycle one-hot accept / reject pulses
//            busy            - burst running or reads still in flight
//            mem_rd_en       - memory read strobe
//            mem_addr        - memory row address
//            mem_rd_data     - memory read data (MEM_LAT cycles after strobe)
//            rd_data         - mem_rd_data passed straight through
//            rd_valid        - one-hot owner of rd_data this cycle
//            rd_last         - one-hot: final row of the owner's burst
// Revision : 1.0 - initial release
// ============================================================================
module row_read_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ROWS    = 480,
  parameter int COLS    = 640,
  parameter int PIX_W   = 8,
  parameter int ROW_AW  = 9,
  parameter int LEN_W   = 9,
  parameter int MEM_LAT = 1,
  localparam int ROW_W  = COLS * PIX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ROW_AW-1:0]   req_addr,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          err,
  output logic                      busy,
  output logic                      mem_rd_en,
  output logic [ROW_AW-1:0]         mem_addr,
  input  logic [ROW_W-1:0]          mem_rd_data,
  output logic [ROW_W-1:0]          rd_data,
  output logic [N_REQ-1:0]          rd_valid,
  output logic [N_REQ-1:0]          rd_last
);

  localparam int                IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0]  ONE      = N_REQ'(1);
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state;
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      cur_id;
  logic [ROW_AW-1:0]   cur_addr;
  logic [LEN_W-1:0]    count;
  logic [N_REQ-1:0]    gnt_q;
  logic [N_REQ-1:0]    err_q;
  logic                rd_en_q;

  // Return pipeline: stage MEM_LAT-1 lines up with the memory data.
  logic [MEM_LAT-1:0]  pipe_vld;
  logic [MEM_LAT-1:0]  pipe_last;
  logic [IDW-1:0]      pipe_id [MEM_LAT];

  // Per-client request fields unpacked for indexing by the winner id.
  logic [ROW_AW-1:0]   addr_arr [N_REQ];
  logic [LEN_W-1:0]    len_arr  [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ROW_AW +: ROW_AW];
    assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
  end

  // A client being rejected this cycle still holds req; ignore it so the
  // same stale request is not arbitrated twice.
  logic [N_REQ-1:0]    cand;
  logic [2*N_REQ-1:0]  rot;
  logic                found;
  logic [IDW-1:0]      win;
  logic [IDW-1:0]      ptr_next;
  logic [ROW_AW-1:0]   win_addr;
  logic [LEN_W-1:0]    win_len;

  assign cand = req & ~err_q;
  // Rotating the doubled vector puts client ptr at bit 0, so the first set
  // bit found scanning upward is the round-robin winner.
  assign rot  = {cand, cand} >> ptr;

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        idx   = int'(ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        win   = IDW'(idx);
      end
    end
  end

  assign ptr_next = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
  assign win_addr = addr_arr[win];
  assign win_len  = len_arr[win];

  // Control FSM: one decision cycle in IDLE, then one row per BURST cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cur_id   <= '0;
      cur_addr <= '0;
      count    <= '0;
      gnt_q    <= '0;
      err_q    <= '0;
      rd_en_q  <= 1'b0;
    end else begin
      gnt_q <= '0;
      err_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            ptr <= ptr_next;
            if (int'(win_addr) >= ROWS) begin
              err_q <= ONE << win;
            end else begin
              state    <= BURST;
              cur_id   <= win;
              cur_addr <= win_addr;
              count    <= win_len;
              gnt_q    <= ONE << win;
              rd_en_q  <= 1'b1;
            end
          end
        end
        BURST: begin
          if (count == '0) begin
            state   <= IDLE;
            rd_en_q <= 1'b0;
          end else begin
            count    <= count - 1'b1;
            cur_addr <= (cur_addr == LAST_ROW) ? '0 : cur_addr + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag each issued read with its owner and last flag, delayed to meet data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_id[i] <= '0;
    end else begin
      pipe_vld[0]  <= rd_en_q;
      pipe_last[0] <= rd_en_q && (count == '0);
      pipe_id[0]   <= cur_id;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_id[i]   <= pipe_id[i-1];
      end
    end
  end

  assign gnt       = gnt_q;
  assign err       = err_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = cur_addr;
  assign busy      = (state == BURST) || (|pipe_vld);
  assign rd_data   = mem_rd_data;
  assign rd_valid  = pipe_vld[MEM_LAT-1] ? (ONE << pipe_id[MEM_LAT-1]) : '0;
  assign rd_last   = (pipe_vld[MEM_LAT-1] && pipe_last[MEM_LAT-1])
                     ? (ONE << pipe_id[MEM_LAT-1]) : '0;

endmodule
`default_nettype wire
